uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DW, default 8: number of data bits per frame.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 RX_IN  in  1  serial line, idle high; already synchronised upstream.
REQ-005 PAR_EN  in  1  1 = frame carries a parity bit.
REQ-006 prescale  in  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 strt_glitch  in  1  start-check result; 1 = start bit sampled high.
REQ-008 par_err  in  1  registered parity-check result.
REQ-009 stp_err  in  1  stop-check result; 1 = stop bit sampled low.
REQ-010 samp_en  out  1  sampler enable.
REQ-011 deser_en  out  1  one-cycle pulse: shift sampled bit into deserialiser.
REQ-012 strt_chk_en / par_chk_en / stp_chk_en  out  1 each  one-cycle check strobes.
REQ-013 data_valid  out  1  one-cycle pulse: deserialised byte is good.
REQ-014 frm_err  out  1  one-cycle pulse: frame dropped (glitch, parity or stop error).

Function
REQ-015 Internal edge_cnt (6 b) SHALL count 0..P-1 per bit; bit_cnt (4 b) SHALL increment when edge_cnt = P-1, where P is the prescale value latched on IDLE exit.
REQ-016 Illegal prescale values SHALL be latched as 8.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and OUT.
REQ-018 IDLE, RX_IN = 0 -> START with edge_cnt = 0 and bit_cnt = 0.
REQ-019 START, edge_cnt = P-1 -> IDLE with frm_err pulse if strt_glitch = 1, else -> DATA.
REQ-020 DATA, edge_cnt = P-1 and bit_cnt = DW -> PARITY if PAR_EN = 1, else -> STOP.
REQ-021 PARITY, edge_cnt = P-1 -> STOP; par_err SHALL be captured into a flag at that edge.
REQ-022 STOP, edge_cnt = P-1 -> OUT if the parity flag = 0 and stp_err = 0, else -> IDLE with frm_err pulse.
REQ-023 OUT SHALL last one cycle with data_valid = 1, then go -> START (edge_cnt = 1) if RX_IN = 0, else -> IDLE.
REQ-024 CHK_EDGE = P/2 + 2.
REQ-025 strt_chk_en, deser_en, par_chk_en and stp_chk_en SHALL each pulse at edge_cnt = CHK_EDGE in START, DATA, PARITY and STOP respectively.
REQ-026 samp_en SHALL be 1 in START, DATA, PARITY and STOP, and 0 otherwise.
REQ-027 PAR_EN SHALL be latched on IDLE exit; changes mid-frame SHALL be ignored.
REQ-028 data_valid and frm_err SHALL never be asserted in the same cycle.

Reset
REQ-029 While rst_n = 0: state = IDLE, counters = 0, parity flag = 0, latched P = 8, all outputs 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no data_valid or frm_err pulse.

Configuration
REQ-031 With UART_RX_BREAK_DET_EN defined: an output port break_det (1 b) SHALL exist.
REQ-032 break_det SHALL pulse for one cycle in place of frm_err when all DW data bits and the stop bit sample 0.
REQ-033 The all-zero data condition SHALL be tracked with an internal sticky flag cleared in START.
REQ-034 Without UART_RX_BREAK_DET_EN: no break_det port and no sticky flag; a break frame yields a frm_err pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef, legal prescale constants, and the CHK_EDGE offset constant (2).
REQ-036 A sub-module uart_rx_edge_bit_cnt SHALL hold edge_cnt and bit_cnt, with enable and clear inputs driven by the FSM.

Verification
REQ-037 Even parity: P = 8, PAR_EN = 1, byte 0xA5, parity bit 0, stop 1 -> 8 deser_en pulses, data_valid 88 cycles after the start edge, frm_err = 0.
REQ-038 Start glitch: RX_IN low for 3 cycles, strt_glitch = 1 at edge_cnt 7, P = 8 -> return to IDLE, frm_err pulse, no deser_en.
REQ-039 Parity error: P = 16, par_err = 1 at PARITY end -> stp_chk_en pulses, then frm_err, no data_valid.
REQ-040 Back-to-back: P = 32, PAR_EN = 0, two frames with no idle gap -> two data_valid pulses, second frame bit timing offset by exactly 1 cycle.
REQ-041 Reset mid-frame: rst_n = 0 during DATA bit 4 -> all outputs 0 immediately; next frame received correctly.
REQ-042 Break, macro defined: frame of 0x00 with stop 0 -> break_det pulse, frm_err = 0, data_valid = 0.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the FSM state encoding, legal oversampling ratios and the check-edge offset.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    OUT    = 3'd5
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8   = 6'd8;
  localparam logic [5:0] PRESCALE_16  = 6'd16;
  localparam logic [5:0] PRESCALE_32  = 6'd32;
  localparam logic [5:0] CHK_EDGE_OFS = 6'd2;

  // Anything other than 16 or 32 falls back to the slowest-safe ratio of 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (0..P-1) and bit counter for the UART receive controller.
// clr_one lets a back-to-back frame resume with edge_cnt = 1 after the one-cycle OUT state.
module uart_rx_edge_bit_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       clr_one,
  input  logic [5:0] p_last,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (clr) begin
      edge_cnt <= {5'd0, clr_one};
      bit_cnt  <= 4'd0;
    end else if (en) begin
      if (edge_cnt == p_last) begin
        edge_cnt <= 6'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing FSM: steers sampler, deserialiser and start/parity/stop checkers.
// Build option UART_RX_BREAK_DET_EN adds a break_det output that replaces frm_err for break frames.
//
//   state  | meaning
//   IDLE   | line idle, counters held clear, waiting for a low sample
//   START  | start bit; glitch result judged on the last edge
//   DATA   | DW data bits, one deser_en per bit
//   PARITY | parity bit; par_err captured on the last edge
//   STOP   | stop bit; frame accepted or dropped on the last edge
//   OUT    | single cycle presenting data_valid
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
`ifdef UART_RX_BREAK_DET_EN
  output logic       break_det,
`endif
  output logic       frm_err
);

  localparam logic [3:0] DW_CNT = 4'(DW);

  rx_state_t  state, next_state;
  logic [5:0] p_lat;
  logic       par_en_lat;
  logic       par_flag;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [5:0] p_last;
  logic [5:0] chk_edge;
  logic       at_chk, at_last;
  logic       cnt_en, cnt_clr, cnt_clr_one;
`ifdef UART_RX_BREAK_DET_EN
  logic       zero_flag;
`endif

  assign p_last   = p_lat - 6'd1;
  assign chk_edge = {1'b0, p_lat[5:1]} + CHK_EDGE_OFS;
  assign at_chk   = (edge_cnt == chk_edge);
  assign at_last  = (edge_cnt == p_last);

  assign cnt_en      = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign cnt_clr     = (state == IDLE) || (state == OUT);
  assign cnt_clr_one = (state == OUT) && !RX_IN;

  uart_rx_edge_bit_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .clr_one  (cnt_clr_one),
    .p_last   (p_last),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      p_lat      <= PRESCALE_8;
      par_en_lat <= 1'b0;
      par_flag   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && !RX_IN) begin
        p_lat      <= legal_prescale(prescale);
        par_en_lat <= PAR_EN;
      end
      if (state == START)
        par_flag <= 1'b0;
      else if (state == PARITY && at_last)
        par_flag <= par_err;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Sticky "every data bit so far was 0", sampled at the same point the deserialiser shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      zero_flag <= 1'b0;
    else if (state == START)
      zero_flag <= 1'b1;
    else if (state == DATA && at_chk && RX_IN)
      zero_flag <= 1'b0;
  end
`endif

  always_comb begin
    next_state  = state;
    samp_en     = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frm_err     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_det   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!RX_IN) next_state = START;
      end
      START: begin
        samp_en     = 1'b1;
        strt_chk_en = at_chk;
        if (at_last) begin
          if (strt_glitch) begin
            next_state = IDLE;
            frm_err    = 1'b1;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        samp_en  = 1'b1;
        deser_en = at_chk;
        if (at_last && bit_cnt == DW_CNT)
          next_state = par_en_lat ? PARITY : STOP;
      end
      PARITY: begin
        samp_en    = 1'b1;
        par_chk_en = at_chk;
        if (at_last) next_state = STOP;
      end
      STOP: begin
        samp_en    = 1'b1;
        stp_chk_en = at_chk;
        if (at_last) begin
          if (!par_flag && !stp_err) begin
            next_state = OUT;
          end else begin
            next_state = IDLE;
`ifdef UART_RX_BREAK_DET_EN
            if (zero_flag && stp_err) break_det = 1'b1;
            else                      frm_err   = 1'b1;
`else
            frm_err = 1'b1;
`endif
          end
        end
      end
      OUT: begin
        data_valid = 1'b1;
        next_state = RX_IN ? IDLE : START;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a frame-level model predicts the cycle of every strobe,
// a monitor compares each DUT strobe against the queued prediction.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  // Output vector: {break_det, frm_err, data_valid, stp_chk, par_chk, deser, strt_chk, samp_en}
  localparam logic [7:0] EV_STRT  = 8'b0000_0011;
  localparam logic [7:0] EV_DESER = 8'b0000_0101;
  localparam logic [7:0] EV_PCHK  = 8'b0000_1001;
  localparam logic [7:0] EV_SCHK  = 8'b0001_0001;
  localparam logic [7:0] EV_DV    = 8'b0010_0000;
  localparam logic [7:0] EV_FERR  = 8'b0100_0001;
  localparam logic [7:0] EV_BRK   = 8'b1000_0001;

  logic       clk = 1'b0;
  logic       rst_n, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
  logic [5:0] prescale;
  logic       samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frm_err;
  logic       break_det;

`ifndef UART_RX_BREAK_DET_EN
  assign break_det = 1'b0;
`endif

  uart_rx_ctrl #(.DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .samp_en     (samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
`ifdef UART_RX_BREAK_DET_EN
    .break_det   (break_det),
`endif
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] outs;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         lat_p = 8;
  bit         lat_par = 1'b0;
  bit         chain = 1'b0;
  logic [7:0] mon_outs;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void push_ev(input int t, input logic [7:0] o, input int cut);
    ev_t e;
    if (cut >= 0 && t >= cut) return;
    e.cyc  = t;
    e.outs = o;
    exp_q.push_back(e);
  endfunction

  task automatic check_zero(input string name);
    logic [7:0] o;
    o = {break_det, frm_err, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en, samp_en};
    n_chk++;
    if (o == 8'h00) n_pass++;
    else $display("FAIL %s outs=%b expected=00000000", name, o);
  endtask

  // One serial frame. Config is taken from the inputs only when the frame starts from idle;
  // a frame following a good frame with no gap inherits the previous configuration.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] ps, input bit pen,
                            input bit glitch, input bit perr, input bit serr,
                            input int gap, input int rst_at);
    int   p, nb, k0, chk, n_samp, cut, b;
    bit   pe, bad;
    logic v;
    if (!chain) begin
      lat_p   = (ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
      lat_par = pen;
    end
    p   = lat_p;
    pe  = lat_par;
    nb  = DW + 2 + (pe ? 1 : 0);
    chk = p / 2 + 2;
    k0  = cyc + 1;
    cut = (rst_at >= 0) ? k0 + rst_at - 1 : -1;
    bad = glitch || serr || (pe && perr);

    push_ev(k0 + chk, EV_STRT, cut);
    if (glitch) begin
      push_ev(k0 + p - 1, EV_FERR, cut);
    end else begin
      for (int i = 1; i <= DW; i++) push_ev(k0 + i * p + chk, EV_DESER, cut);
      if (pe) push_ev(k0 + (DW + 1) * p + chk, EV_PCHK, cut);
      push_ev(k0 + (nb - 1) * p + chk, EV_SCHK, cut);
      if (!bad)                                push_ev(k0 + nb * p, EV_DV, cut);
      else if (BRK && serr && data == 8'h00)   push_ev(k0 + nb * p - 1, EV_BRK, cut);
      else                                     push_ev(k0 + nb * p - 1, EV_FERR, cut);
    end

    n_samp = glitch ? p : nb * p;
    for (int s = 0; s < n_samp; s++) begin
      if (s == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_frame");
        RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chain = 1'b0;
        return;
      end
      b = s / p;
      if (glitch)                   v = (s >= 3) ? 1'b1 : 1'b0;
      else if (b == 0)              v = 1'b0;
      else if (b <= DW)             v = data[b-1];
      else if (pe && b == DW + 1)   v = ^data;
      else                          v = ~serr;
      RX_IN = v;
      if (s == 0) begin
        PAR_EN   = pen;
        prescale = ps;
      end
      if (s == 1) begin
        strt_glitch = glitch;
        par_err     = perr;
        stp_err     = serr;
      end
      if (s == 2) begin
        PAR_EN   = 1'($urandom);
        prescale = 6'($urandom);
      end
      tick();
    end
    RX_IN = 1'b1;
    repeat (gap) tick();
    chain = !bad && gap == 0;
  endtask

  // Monitor: every strobe must match the oldest prediction in both cycle and output vector.
  initial begin
    forever begin
      @(negedge clk);
      mon_outs = {break_det, frm_err, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en, samp_en};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_chk++;
        $display("FAIL missed_event cyc=%0d got=none expected_cyc=%0d expected_outs=%b",
                 cyc, exp_q[0].cyc, exp_q[0].outs);
        void'(exp_q.pop_front());
      end
      if (|mon_outs[7:1]) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_strobe cyc=%0d outs=%b expected=nothing", cyc, mon_outs);
        end else if (exp_q[0].cyc == cyc && exp_q[0].outs == mon_outs) begin
          n_pass++;
          void'(exp_q.pop_front());
        end else begin
          $display("FAIL strobe cyc=%0d outs=%b expected_cyc=%0d expected_outs=%b",
                   cyc, mon_outs, exp_q[0].cyc, exp_q[0].outs);
          if (exp_q[0].cyc == cyc) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [5:0] ps;
    bit         pen, gl, pr, se, ok;
    int         g;

    rst_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #2;
    check_zero("reset_state");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // data, prescale, par_en, glitch, par_err, stp_err, gap, reset sample
    send_frame(8'hA5, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 3, -1);   // even parity, 88-cycle frame
    send_frame(8'hFF, 6'd8,  1'b0, 1'b1, 1'b0, 1'b0, 3, -1);   // start glitch
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b0, 3, -1);   // parity error
    send_frame(8'h96, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);   // back-to-back pair
    send_frame(8'h4B, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 3, -1);   // inherits P=32, no parity
    send_frame(8'hC3, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 3, 35);   // reset during data bit 4
    send_frame(8'h5A, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 3, -1);   // clean frame after reset
    send_frame(8'h00, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);   // break frame
    send_frame(8'h81, 6'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2, -1);   // illegal prescale -> 8

    for (int f = 0; f < 20; f++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      case ($urandom_range(0, 3))
        0:       ps = 6'd8;
        1:       ps = 6'd16;
        2:       ps = 6'd32;
        default: ps = 6'($urandom_range(0, 63));
      endcase
      pen = 1'($urandom);
      gl  = ($urandom_range(0, 9) == 0);
      pr  = ($urandom_range(0, 4) == 0);
      se  = ($urandom_range(0, 5) == 0);
      ok  = !gl && !se && !pr;
      g   = $urandom_range(1, 4);
      if (g == 1) g = ok ? 0 : 2;
      send_frame(d, ps, pen, gl, pr, se, g, -1);
    end

    RX_IN = 1'b1;
    repeat (30) tick();
    while (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL leftover_event got=none expected_cyc=%0d expected_outs=%b",
               exp_q[0].cyc, exp_q[0].outs);
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
